uart_tx_fifo_cfg: RTL and testbench
===================================

// Module: uart_tx_fifo_cfg
// PURPOSE
//   Parametrised UART transmitter, next generation of the 8N1 TX. Adds a small transmit FIFO,
//   compile-time frame format (data bits, parity, stop bits) and a run-time baud divisor.
//   Sits between the report/telemetry formatter and the board UART pin. It sends
//   back-to-back frames with no idle gap while data is queued.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
//   PARITY      0   0 = none, 1 = even, 2 = odd
//   STOP_BITS   1   stop bits per frame, legal 1 or 2
//   FIFO_DEPTH  4   TX FIFO entries, power of two, >= 2
//   DIV_W       16  width of the baud divisor input
// PORTS
//   clk           in   1                     system clock, all logic on rising edge
//   rst           in   1                     synchronous, active-high reset
//   clks_per_bit  in   DIV_W                 clock cycles per bit, sampled at frame start
//   in_data       in   DATA_BITS             word to transmit
//   in_valid      in   1                     in_data valid
//   in_ready      out  1                     FIFO can accept; beat taken when in_valid && in_ready
//   tx            out  1                     serial line, idle high, registered
//   busy          out  1                     frame in progress (state != IDLE)
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  entries queued, not counting the frame in flight
// BEHAVIOUR
//   Reset (rst=1 at an edge): tx=1, busy=0, fifo_level=0, in_ready=0 while rst is high.
//     FIFO is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame.
//     tx is 1 from the first edge with rst high.
//   FIFO: in_ready = !full && !rst. Push on accepted beat. Pop only by the FSM in IDLE or at
//     the end of the last stop bit. If a push and a pop occur in the same cycle, fifo_level is
//     unchanged. A push into a full FIFO cannot occur because in_ready is low. Pointers wrap
//     modulo FIFO_DEPTH.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//     IDLE: tx=1. If the FIFO is non-empty: pop into the shift register, latch the divisor,
//       compute parity, go to START. tx=0 from that same edge.
//     START/DATA/PARITY/STOP: each bit holds tx for exactly D cycles. D = latched divisor;
//       a latched value < 2 is treated as 2. bit_cnt counts DATA_BITS data bits LSB first,
//       then STOP_BITS stop bits (tx=1).
//     PARITY: present only when PARITY != 0. Even parity bit = XOR of data bits.
//       Odd parity bit = ~XOR of data bits.
//     End of the last stop bit: if the FIFO is non-empty, pop and enter START directly with
//       zero idle cycles. Otherwise enter IDLE.
//   Latency: beat accepted at edge E into an empty FIFO with the FSM idle. Pop at E+1;
//     tx falls at E+1.
//   Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * D cycles.
//   clks_per_bit changes mid-frame have no effect until the next frame start.
//   busy=1 from the edge that enters START until the edge that returns to IDLE.
//   Counter widths: baud counter DIV_W bits, no overflow for legal D. A counter compare
//     against D-1 ends each bit.
// TESTING
//   8N1, D=4, send 0xA5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each),
//     then high 4; busy high 40 cycles.
//   PARITY=1, D=3, send 0x07 -> parity bit 1 after data. PARITY=2, same data -> parity bit 0.
//   STOP_BITS=2, D=2, send 0x00 then 0xFF back to back -> stop held 4 cycles, next start bit
//     with no idle gap, busy stays 1.
//   FIFO_DEPTH=4, hold in_valid with 6 words while the first frame sends -> 5 accepted
//     (1 in flight + 4 queued), in_ready drops at level 4 and rises after the next pop;
//     all words emitted in order.
//   clks_per_bit=0 and 1 -> bit period is 2 cycles. Change D from 4 to 8 mid-frame ->
//     current frame stays at 4, next frame uses 8.
//   Assert rst during DATA bit 3 -> tx=1 and busy=0 next edge, fifo_level=0. After release,
//     a new word is sent with a correct full frame.

Source files
------------

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: UART transmitter with a small TX FIFO, compile-time frame
// format (data bits, optional parity, 1 or 2 stop bits) and a run-time baud
// divisor latched at each frame start. Frames go out back to back while the
// FIFO holds data.
module uart_tx_fifo_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              clks_per_bit,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BCW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Transmit datapath / FSM registers and their next values
    state_t               state,    state_n;
    logic [DATA_BITS-1:0] shreg,    shreg_n;
    logic [DIV_W-1:0]     div_q,    div_n;
    logic [DIV_W-1:0]     baud_cnt, baud_n;
    logic [BCW-1:0]       bit_cnt,  bit_n;
    logic                 par_q,    par_n;
    logic                 tx_q,     tx_n;
    logic                 bit_end;
    logic                 load;
    logic [DATA_BITS-1:0] head;
    logic [DIV_W-1:0]     div_clamped;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign fifo_level = count;
    assign head       = mem[rd_ptr];

    assign div_clamped = (clks_per_bit < DIV_W'(2)) ? DIV_W'(2) : clks_per_bit;
    assign bit_end     = (baud_cnt == div_q - DIV_W'(1));

    assign tx   = tx_q;
    assign busy = (state != S_IDLE);

    // FIFO storage write on every accepted beat
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM and datapath state register; reset aborts any frame and idles the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            div_q    <= DIV_W'(2);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            div_q    <= div_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
        end
    end

    // Next-state logic: bit sequencing, and frame load from IDLE or straight
    // out of the last stop bit so consecutive frames have no idle gap
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div_q;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        par_n   = par_q;
        tx_n    = tx_q;
        load    = 1'b0;
        pop     = 1'b0;

        if (state != S_IDLE) begin
            baud_n = bit_end ? '0 : baud_cnt + DIV_W'(1);
        end

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                        bit_n   = bit_cnt + BCW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == BCW'(STOP_BITS - 1)) begin
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BCW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        if (load) begin
            pop     = 1'b1;
            shreg_n = head;
            div_n   = div_clamped;
            par_n   = (PARITY == 2) ? ~^head : ^head;
            baud_n  = '0;
            bit_n   = '0;
            state_n = S_START;
            tx_n    = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed tests for uart_tx_fifo_cfg across several
// frame formats (8N1, 8E1, 8O1, 8N2), each on its own instance.
module tb_uart_tx_fifo_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpb [4];
    logic [7:0]  din [4];
    logic        vin [4];
    logic        rdy [4];
    logic        txo [4];
    logic        bsy [4];
    logic [2:0]  lvl [4];

    int checks = 0;
    int errors = 0;

    logic cap_tx  [$];
    logic cap_bsy [$];

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_8n1 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb[0]), .in_data(din[0]), .in_valid(vin[0]),
        .in_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .fifo_level(lvl[0]));
    uart_tx_fifo_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_8e1 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb[1]), .in_data(din[1]), .in_valid(vin[1]),
        .in_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .fifo_level(lvl[1]));
    uart_tx_fifo_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_8o1 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb[2]), .in_data(din[2]), .in_valid(vin[2]),
        .in_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .fifo_level(lvl[2]));
    uart_tx_fifo_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u_8n2 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb[3]), .in_data(din[3]), .in_valid(vin[3]),
        .in_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .fifo_level(lvl[3]));

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic push(input int k, input logic [7:0] d);
        int t;
        t = 0;
        din[k] = d;
        vin[k] = 1'b1;
        while (!rdy[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!rdy[k]) begin
            errors++;
            $display("FAIL push_timeout inst %0d in_ready=%b required 1", k, rdy[k]);
            vin[k] = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            vin[k] = 1'b0;
        end
    endtask

    // Records tx/busy now and on each following falling edge, n samples total.
    task automatic capture(input int k, input int n);
        cap_tx.delete();
        cap_bsy.delete();
        for (int i = 0; i < n; i++) begin
            cap_tx.push_back(txo[k]);
            cap_bsy.push_back(bsy[k]);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (txo[k] !== 1'b1) begin errors++; $display("FAIL reset_tx inst %0d got %b exp 1", k, txo[k]); end
            checks++;
            if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d got %b exp 0", k, bsy[k]); end
            checks++;
            if (lvl[k] !== 3'd0) begin errors++; $display("FAIL reset_level inst %0d got %0d exp 0", k, lvl[k]); end
            checks++;
            if (rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_ready inst %0d got %b exp 0", k, rdy[k]); end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", rdy[0]); end
    endtask

    task automatic test_basic_8n1();
        logic [9:0] f;
        logic       et;
        f = 10'b1101001010;
        cpb[0] = 16'd4;
        push(0, 8'hA5);
        checks++;
        if (txo[0] !== 1'b1) begin errors++; $display("FAIL latency_tx got %b exp 1", txo[0]); end
        checks++;
        if (lvl[0] !== 3'd1) begin errors++; $display("FAIL latency_level got %0d exp 1", lvl[0]); end
        @(negedge clk);
        capture(0, 41);
        for (int i = 0; i < 41; i++) begin
            et = (i < 40) ? f[i / 4] : 1'b1;
            checks++;
            if (cap_tx[i] !== et) begin errors++; $display("FAIL a5_tx[%0d] got %b exp %b", i, cap_tx[i], et); end
            checks++;
            if (cap_bsy[i] !== (i < 40)) begin errors++; $display("FAIL a5_busy[%0d] got %b exp %b", i, cap_bsy[i], (i < 40)); end
        end
    endtask

    task automatic test_parity();
        logic [10:0] f;
        logic        et;
        for (int k = 1; k <= 2; k++) begin
            f = (k == 1) ? 11'b11000001110 : 11'b10000001110;
            cpb[k] = 16'd3;
            push(k, 8'h07);
            @(negedge clk);
            capture(k, 34);
            for (int i = 0; i < 34; i++) begin
                et = (i < 33) ? f[i / 3] : 1'b1;
                checks++;
                if (cap_tx[i] !== et) begin errors++; $display("FAIL parity%0d_tx[%0d] got %b exp %b", k, i, cap_tx[i], et); end
            end
            checks++;
            if (cap_bsy[33] !== 1'b0) begin errors++; $display("FAIL parity%0d_busy_end got %b exp 0", k, cap_bsy[33]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] f;
        logic        et;
        f = {11'b11111111110, 11'b11000000000};
        cpb[3] = 16'd2;
        din[3] = 8'h00;
        vin[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din[3] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        vin[3] = 1'b0;
        capture(3, 45);
        for (int i = 0; i < 45; i++) begin
            et = (i < 44) ? f[i / 2] : 1'b1;
            checks++;
            if (cap_tx[i] !== et) begin errors++; $display("FAIL b2b_tx[%0d] got %b exp %b", i, cap_tx[i], et); end
            checks++;
            if (cap_bsy[i] !== (i < 44)) begin errors++; $display("FAIL b2b_busy[%0d] got %b exp %b", i, cap_bsy[i], (i < 44)); end
        end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] w [6];
        int         idx;
        int         rise;
        logic       r;
        logic       et;
        int         bp;
        w = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h5A, 8'h01};
        idx = 0;
        rise = -1;
        cpb[0] = 16'd2;
        fork
            begin
                din[0] = w[0];
                vin[0] = 1'b1;
                for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
                    r = rdy[0];
                    if (cyc == 4) begin
                        checks++;
                        if (lvl[0] !== 3'd3 || r !== 1'b1) begin
                            errors++; $display("FAIL fifo_lvl3 level=%0d ready=%b exp level=3 ready=1", lvl[0], r);
                        end
                    end
                    if (cyc == 5) begin
                        checks++;
                        if (lvl[0] !== 3'd4 || r !== 1'b0 || idx != 5) begin
                            errors++; $display("FAIL fifo_full level=%0d ready=%b accepted=%0d exp 4 0 5", lvl[0], r, idx);
                        end
                    end
                    if (idx == 5 && r && rise < 0) rise = cyc;
                    @(posedge clk);
                    if (r) idx++;
                    @(negedge clk);
                    if (idx < 6) din[0] = w[idx];
                    else vin[0] = 1'b0;
                end
                vin[0] = 1'b0;
            end
            begin
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                capture(0, 121);
            end
        join
        checks++;
        if (idx != 6) begin errors++; $display("FIFO accepted: FAIL fifo_accept got %0d exp 6", idx); end
        checks++;
        if (rise != 22) begin errors++; $display("FAIL fifo_ready_rise got cycle %0d exp 22", rise); end
        for (int i = 0; i < 121; i++) begin
            if (i < 120) begin
                bp = (i % 20) / 2;
                if (bp == 0) et = 1'b0;
                else if (bp == 9) et = 1'b1;
                else et = w[i / 20][bp - 1];
            end else begin
                et = 1'b1;
            end
            checks++;
            if (cap_tx[i] !== et) begin errors++; $display("FAIL fifo_tx[%0d] got %b exp %b", i, cap_tx[i], et); end
        end
        checks++;
        if (cap_bsy[119] !== 1'b1 || cap_bsy[120] !== 1'b0) begin
            errors++; $display("FAIL fifo_busy_end got %b%b exp 10", cap_bsy[119], cap_bsy[120]);
        end
    endtask

    task automatic test_divisor();
        logic [9:0] f;
        logic [9:0] f1;
        logic [9:0] f2;
        logic       et;
        f  = 10'b1010101010;
        f1 = 10'b1111100000;
        f2 = 10'b1000011110;
        for (int v = 0; v < 2; v++) begin
            cpb[0] = 16'(v);
            push(0, 8'h55);
            @(negedge clk);
            capture(0, 21);
            for (int i = 0; i < 21; i++) begin
                et = (i < 20) ? f[i / 2] : 1'b1;
                checks++;
                if (cap_tx[i] !== et) begin errors++; $display("FAIL div%0d_tx[%0d] got %b exp %b", v, i, cap_tx[i], et); end
            end
        end
        cpb[0] = 16'd4;
        push(0, 8'hF0);
        @(negedge clk);
        fork
            capture(0, 121);
            begin
                cpb[0] = 16'd8;
                din[0] = 8'h0F;
                vin[0] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                vin[0] = 1'b0;
            end
        join
        for (int i = 0; i < 121; i++) begin
            if (i < 40) et = f1[i / 4];
            else if (i < 120) et = f2[(i - 40) / 8];
            else et = 1'b1;
            checks++;
            if (cap_tx[i] !== et) begin errors++; $display("FAIL divchg_tx[%0d] got %b exp %b", i, cap_tx[i], et); end
            checks++;
            if (cap_bsy[i] !== (i < 120)) begin errors++; $display("FAIL divchg_busy[%0d] got %b exp %b", i, cap_bsy[i], (i < 120)); end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] f;
        logic       et;
        f = 10'b1100101100;
        cpb[0] = 16'd4;
        push(0, 8'hA5);
        push(0, 8'h3C);
        checks++;
        if (lvl[0] !== 3'd1) begin errors++; $display("FAIL midrst_level_before got %0d exp 1", lvl[0]); end
        repeat (17) @(negedge clk);
        checks++;
        if (txo[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_in_bit3 tx=%b busy=%b exp tx=0 busy=1", txo[0], bsy[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (txo[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", txo[0]); end
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bsy[0]); end
        checks++;
        if (lvl[0] !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", lvl[0]); end
        checks++;
        if (rdy[0] !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", rdy[0]); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txo[0] !== 1'b1 || bsy[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            errors++; $display("FAIL postrst_idle tx=%b busy=%b level=%0d exp 1 0 0", txo[0], bsy[0], lvl[0]);
        end
        push(0, 8'h96);
        @(negedge clk);
        capture(0, 41);
        for (int i = 0; i < 41; i++) begin
            et = (i < 40) ? f[i / 4] : 1'b1;
            checks++;
            if (cap_tx[i] !== et) begin errors++; $display("FAIL postrst_tx[%0d] got %b exp %b", i, cap_tx[i], et); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpb[k] = 16'd4;
            din[k] = 8'h00;
            vin[k] = 1'b0;
        end
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_fifo_fill();
        test_divisor();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
